// File: rtl/egd_pkg.sv
// Shared constants and packer state type for the exp-Golomb bitstream feeder.
package egd_pkg;
  localparam logic [7:0]  EGD_EPB_BYTE = 8'h03;
  localparam logic [7:0]  EGD_SC_BYTE  = 8'h01;
  localparam int unsigned EGD_WORD_W   = 16;

  typedef enum logic [1:0] {EMPTY, HALF, FULL} pk_state_t;
endpackage

// File: rtl/egd_bitstream_feeder_if.sv
// Byte-in / word-out handshake bundle of the bitstream feeder.
interface egd_bitstream_feeder_if;
  import egd_pkg::*;

  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [EGD_WORD_W-1:0] word_data;
  logic                  word_valid;
  logic                  word_ready;

  modport master (output in_data, in_valid, word_ready,
                  input  in_ready, word_data, word_valid);
  modport slave  (input  in_data, in_valid, word_ready,
                  output in_ready, word_data, word_valid);
endinterface

// File: rtl/egd_byte_fifo.sv
// Synchronous-write, show-ahead byte FIFO with full/empty/level and synchronous flush.
module egd_byte_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(FIFO_DEPTH);

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_level;
  logic              w_push;
  logic              w_pop;

  assign full    = (r_level == DEPTH);
  assign empty   = (r_level == '0);
  assign level   = r_level;
  assign rd_data = r_mem[r_rptr];
  assign w_push  = wr_en & ~full & ~flush;
  // Pop is gated on registered empty, so a push into an empty FIFO is not read the same cycle.
  assign w_pop   = rd_en & ~empty & ~flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wr_data;
  end
endmodule

// File: rtl/egd_bitstream_feeder.sv
// NAL byte feeder: emulation-prevention strip, start-code pulse, byte FIFO, 16-bit big-endian packer.
// Optional EGD_FEEDER_STATS_EN adds a saturating epb_count output of dropped 0x03 bytes.
module egd_bitstream_feeder
  import egd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  egd_bitstream_feeder_if.slave  bus,
  output logic                   start_code,
  output logic [ADDR_W:0]        fifo_level
`ifdef EGD_FEEDER_STATS_EN
  ,
  output logic [15:0]            epb_count
`endif
);
  logic [1:0]            r_zcnt;
  logic                  r_start;
  pk_state_t             r_state;
  logic [7:0]            r_hi;
  logic [EGD_WORD_W-1:0] r_word_data;
  logic                  r_word_valid;

  logic       w_full, w_empty, w_in_ready, w_accept, w_zrun;
  logic       w_drop, w_sc, w_wr, w_pop;
  logic [7:0] w_rd_data;

  assign w_in_ready = ~w_full & ~flush;
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_zrun     = (r_zcnt == 2'd2);
  assign w_drop     = w_accept & w_zrun & (bus.in_data == EGD_EPB_BYTE);
  assign w_sc       = w_accept & w_zrun & (bus.in_data == EGD_SC_BYTE);
  assign w_wr       = w_accept & ~w_drop;

  always_comb begin
    w_pop = 1'b0;
    if (!flush && !w_empty) begin
      case (r_state)
        EMPTY, HALF: w_pop = 1'b1;
        FULL:        w_pop = bus.word_ready;
        default:     w_pop = 1'b0;
      endcase
    end
  end

  egd_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .wr_en   (w_wr),
    .wr_data (bus.in_data),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_zcnt  <= '0;
      r_start <= 1'b0;
    end else if (flush) begin
      r_zcnt  <= '0;
      r_start <= 1'b0;
    end else begin
      r_start <= w_sc;
      if (w_accept) begin
        if (w_drop || w_sc)          r_zcnt <= '0;
        else if (bus.in_data == '0)  r_zcnt <= w_zrun ? 2'd2 : r_zcnt + 2'd1;
        else                         r_zcnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= EMPTY;
      r_hi         <= '0;
      r_word_data  <= '0;
      r_word_valid <= 1'b0;
    end else if (flush) begin
      r_state      <= EMPTY;
      r_word_valid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: if (!w_empty) begin
          r_hi    <= w_rd_data;
          r_state <= HALF;
        end
        HALF: if (!w_empty) begin
          r_word_data  <= {r_hi, w_rd_data};
          r_word_valid <= 1'b1;
          r_state      <= FULL;
        end
        FULL: if (bus.word_ready) begin
          r_word_valid <= 1'b0;
          if (!w_empty) begin
            r_hi    <= w_rd_data;
            r_state <= HALF;
          end else begin
            r_state <= EMPTY;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

`ifdef EGD_FEEDER_STATS_EN
  logic [15:0] r_epb_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         r_epb_count <= '0;
    else if (flush)                       r_epb_count <= '0;
    else if (w_drop && r_epb_count != '1) r_epb_count <= r_epb_count + 16'd1;
  end

  assign epb_count = r_epb_count;
`endif

  assign bus.in_ready   = w_in_ready;
  assign bus.word_data  = r_word_data;
  assign bus.word_valid = r_word_valid;
  assign start_code     = r_start;
endmodule

// File: tb/tb_egd_bitstream_feeder.sv
// Self-checking bench for egd_bitstream_feeder: directed scenarios plus a randomized
// run checked against a stream-level model of EPB removal, start-code detection and packing.
module tb_egd_bitstream_feeder;
  localparam int FIFO_DEPTH = 8;
  localparam int ADDR_W     = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              flush = 1'b0;
  logic              start_code;
  logic [ADDR_W:0]   fifo_level;
`ifdef EGD_FEEDER_STATS_EN
  logic [15:0]       epb_count;
`endif

  egd_bitstream_feeder_if bus ();

  egd_bitstream_feeder #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .bus        (bus),
    .start_code (start_code),
    .fifo_level (fifo_level)
`ifdef EGD_FEEDER_STATS_EN
    ,
    .epb_count  (epb_count)
`endif
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] got_q[$];
  int          sc_total = 0;

  always @(posedge clk) begin
    if (bus.word_valid && bus.word_ready) got_q.push_back(bus.word_data);
    if (start_code) sc_total++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: a 0x03 is removed when the two most recent kept bytes are 00 00 and
  // neither precedes an earlier removal; a 0x01 in the same position is a start code.
  function automatic void ref_model(input logic [7:0] bytes[$], output logic [15:0] words[$],
                                    output int n_sc, output int n_epb);
    logic [7:0] kept[$];
    int last_drop = 0;
    bit two_zeros;
    n_sc = 0;
    n_epb = 0;
    words.delete();
    foreach (bytes[i]) begin
      two_zeros = (kept.size() - last_drop >= 2) &&
                  kept[kept.size()-1] == 8'h00 && kept[kept.size()-2] == 8'h00;
      if (two_zeros && bytes[i] == 8'h03) begin
        n_epb++;
        last_drop = kept.size();
      end else begin
        if (two_zeros && bytes[i] == 8'h01) n_sc++;
        kept.push_back(bytes[i]);
      end
    end
    for (int i = 0; i + 1 < kept.size(); i += 2) words.push_back({kept[i], kept[i+1]});
  endfunction

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return 8'h00;
      4, 5:       return 8'h03;
      6:          return 8'h01;
      default:    return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic push_byte(input logic [7:0] b, output bit ok);
    int unsigned t = 0;
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    ok = bus.in_ready;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_words(input int target, input int limit);
    int t = 0;
    while (got_q.size() < target && t < limit) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.word_ready = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (fifo_level !== '0) begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    tests_run++;
    if (bus.word_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_word_valid: got %b expected 0", bus.word_valid); end
    tests_run++;
    if (bus.word_data !== 16'h0000) begin tests_failed++; $display("FAIL reset_word_data: got %h expected 0000", bus.word_data); end
    tests_run++;
    if (start_code !== 1'b0) begin tests_failed++; $display("FAIL reset_start_code: got %b expected 0", start_code); end
`ifdef EGD_FEEDER_STATS_EN
    tests_run++;
    if (epb_count !== 16'h0) begin tests_failed++; $display("FAIL reset_epb_count: got %0d expected 0", epb_count); end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    bit ok;
    int stalls = 0;
    int base;
    do_flush();
    base = got_q.size();
    bus.word_ready = 1'b1;
    push_byte(8'h12, ok); if (!ok) stalls++;
    push_byte(8'h34, ok); if (!ok) stalls++;
    // 0x34 accepted at this edge: valid stays low one more edge, then rises.
    tests_run++;
    if (bus.word_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_latency_early: got %b expected 0", bus.word_valid); end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.word_valid !== 1'b1 || bus.word_data !== 16'h1234) begin
      tests_failed++;
      $display("FAIL basic_latency: got valid=%b data=%h expected valid=1 data=1234", bus.word_valid, bus.word_data);
    end
    push_byte(8'h56, ok); if (!ok) stalls++;
    push_byte(8'h78, ok); if (!ok) stalls++;
    wait_words(base + 2, 50);
    tests_run++;
    if (got_q.size() != base + 2) begin tests_failed++; $display("FAIL basic_count: got %0d expected 2", got_q.size() - base); end
    else begin
      tests_run++;
      if (got_q[base] !== 16'h1234 || got_q[base+1] !== 16'h5678) begin
        tests_failed++;
        $display("FAIL basic_words: got %h %h expected 1234 5678", got_q[base], got_q[base+1]);
      end
    end
    tests_run++;
    if (stalls != 0) begin tests_failed++; $display("FAIL basic_accept: got %0d stalled bytes expected 0", stalls); end
  endtask

  task automatic test_epb();
    logic [7:0] seq[8] = '{8'h00, 8'h00, 8'h03, 8'h01, 8'h00, 8'h00, 8'h03, 8'h02};
    logic [15:0] exp_w[3] = '{16'h0000, 16'h0100, 16'h0002};
    bit ok;
    int base, sc_base;
    do_flush();
    base = got_q.size();
    sc_base = sc_total;
    bus.word_ready = 1'b1;
    foreach (seq[i]) push_byte(seq[i], ok);
    wait_words(base + 3, 50);
    repeat (3) @(negedge clk);
    tests_run++;
    if (got_q.size() != base + 3) begin tests_failed++; $display("FAIL epb_count_words: got %0d expected 3", got_q.size() - base); end
    else foreach (exp_w[i]) begin
      tests_run++;
      if (got_q[base+i] !== exp_w[i]) begin tests_failed++; $display("FAIL epb_word%0d: got %h expected %h", i, got_q[base+i], exp_w[i]); end
    end
    tests_run++;
    if (sc_total != sc_base) begin tests_failed++; $display("FAIL epb_no_start: got %0d pulses expected 0", sc_total - sc_base); end
`ifdef EGD_FEEDER_STATS_EN
    tests_run++;
    if (epb_count !== 16'd2) begin tests_failed++; $display("FAIL epb_stat: got %0d expected 2", epb_count); end
`endif
  endtask

  task automatic test_start_code();
    bit ok;
    int base, sc_base;
    do_flush();
    base = got_q.size();
    sc_base = sc_total;
    bus.word_ready = 1'b1;
    push_byte(8'h00, ok);
    push_byte(8'h00, ok);
    push_byte(8'h01, ok);
    tests_run++;
    if (start_code !== 1'b1) begin tests_failed++; $display("FAIL sc_pulse: got %b expected 1", start_code); end
    @(posedge clk);
    #1;
    tests_run++;
    if (start_code !== 1'b0) begin tests_failed++; $display("FAIL sc_pulse_end: got %b expected 0", start_code); end
    push_byte(8'hAB, ok);
    wait_words(base + 2, 50);
    repeat (3) @(negedge clk);
    tests_run++;
    if (got_q.size() != base + 2) begin tests_failed++; $display("FAIL sc_count_words: got %0d expected 2", got_q.size() - base); end
    else begin
      tests_run++;
      if (got_q[base] !== 16'h0000 || got_q[base+1] !== 16'h01AB) begin
        tests_failed++;
        $display("FAIL sc_words: got %h %h expected 0000 01ab", got_q[base], got_q[base+1]);
      end
    end
    tests_run++;
    if (sc_total - sc_base != 1) begin tests_failed++; $display("FAIL sc_pulses: got %0d expected 1", sc_total - sc_base); end
  endtask

  task automatic test_backpressure();
    logic [7:0] b[10];
    bit ok;
    int stalls = 0;
    int base;
    do_flush();
    base = got_q.size();
    bus.word_ready = 1'b0;
    foreach (b[i]) b[i] = 8'($urandom_range(16, 255));
    foreach (b[i]) begin push_byte(b[i], ok); if (!ok) stalls++; end
    @(negedge clk);
    tests_run++;
    if (stalls != 0) begin tests_failed++; $display("FAIL bp_accept: got %0d stalled bytes expected 0", stalls); end
    tests_run++;
    if (fifo_level !== 4'(FIFO_DEPTH) || bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_full: got level=%0d in_ready=%b expected level=%0d in_ready=0", fifo_level, bus.in_ready, FIFO_DEPTH);
    end
    repeat (5) @(negedge clk);
    tests_run++;
    if (bus.word_valid !== 1'b1 || bus.word_data !== {b[0], b[1]} || got_q.size() != base) begin
      tests_failed++;
      $display("FAIL bp_hold: got valid=%b data=%h taken=%0d expected valid=1 data=%h taken=0",
               bus.word_valid, bus.word_data, got_q.size() - base, {b[0], b[1]});
    end
    bus.word_ready = 1'b1;
    wait_words(base + 5, 100);
    tests_run++;
    if (got_q.size() != base + 5) begin tests_failed++; $display("FAIL bp_drain: got %0d words expected 5", got_q.size() - base); end
    else for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (got_q[base+i] !== {b[2*i], b[2*i+1]}) begin
        tests_failed++;
        $display("FAIL bp_word%0d: got %h expected %h", i, got_q[base+i], {b[2*i], b[2*i+1]});
      end
    end
  endtask

  task automatic test_flush();
    bit ok;
    int base;
    do_flush();
    bus.word_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_byte(8'($urandom_range(16, 255)), ok);
    @(negedge clk);
    bus.word_ready = 1'b1;
    @(negedge clk);
    bus.word_ready = 1'b0;
    tests_run++;
    if (fifo_level !== 4'd3 || bus.word_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_setup: got level=%0d valid=%b expected level=3 valid=0", fifo_level, bus.word_valid);
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    tests_run++;
    if (fifo_level !== '0 || bus.word_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_clear: got level=%0d valid=%b expected level=0 valid=0", fifo_level, bus.word_valid);
    end
    base = got_q.size();
    bus.word_ready = 1'b1;
    push_byte(8'hAA, ok);
    push_byte(8'hBB, ok);
    wait_words(base + 1, 50);
    repeat (4) @(negedge clk);
    tests_run++;
    if (got_q.size() != base + 1) begin tests_failed++; $display("FAIL flush_after_count: got %0d expected 1", got_q.size() - base); end
    else begin
      tests_run++;
      if (got_q[base] !== 16'hAABB) begin tests_failed++; $display("FAIL flush_after_word: got %h expected aabb", got_q[base]); end
    end
  endtask

  task automatic test_random();
    logic [7:0]  bytes[$];
    logic [15:0] exp_w[$];
    int n_sc, n_epb, base, sc_base;
    int stalls = 0;
    bit drv_done = 1'b0;
    do_flush();
    base = got_q.size();
    sc_base = sc_total;
    for (int i = 0; i < 300; i++) bytes.push_back(rand_byte());
    ref_model(bytes, exp_w, n_sc, n_epb);
    fork
      begin
        bit ok;
        foreach (bytes[i]) begin
          if ($urandom_range(0, 3) == 0) @(negedge clk);
          push_byte(bytes[i], ok);
          if (!ok) stalls++;
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(negedge clk);
          bus.word_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.word_ready = 1'b1;
    wait_words(base + exp_w.size(), 500);
    repeat (4) @(negedge clk);
    tests_run++;
    if (stalls != 0) begin tests_failed++; $display("FAIL rand_accept: got %0d stalled bytes expected 0", stalls); end
    tests_run++;
    if (got_q.size() != base + exp_w.size()) begin
      tests_failed++;
      $display("FAIL rand_count: got %0d words expected %0d", got_q.size() - base, exp_w.size());
    end else foreach (exp_w[i]) begin
      tests_run++;
      if (got_q[base+i] !== exp_w[i]) begin tests_failed++; $display("FAIL rand_word%0d: got %h expected %h", i, got_q[base+i], exp_w[i]); end
    end
    tests_run++;
    if (sc_total - sc_base != n_sc) begin tests_failed++; $display("FAIL rand_start: got %0d expected %0d", sc_total - sc_base, n_sc); end
`ifdef EGD_FEEDER_STATS_EN
    tests_run++;
    if (epb_count !== 16'(n_epb)) begin tests_failed++; $display("FAIL rand_epb: got %0d expected %0d", epb_count, n_epb); end
`endif
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base;
    do_flush();
    bus.word_ready = 1'b0;
    push_byte(8'h5A, ok);
    push_byte(8'hC3, ok);
    push_byte(8'h77, ok);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (bus.word_valid !== 1'b0 || bus.word_data !== 16'h0000 || fifo_level !== '0 || start_code !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got valid=%b data=%h level=%0d sc=%b expected 0 0000 0 0",
               bus.word_valid, bus.word_data, fifo_level, start_code);
    end
    @(negedge clk);
    reset_n = 1'b1;
    base = got_q.size();
    bus.word_ready = 1'b1;
    push_byte(8'h12, ok);
    push_byte(8'h34, ok);
    wait_words(base + 1, 50);
    repeat (4) @(negedge clk);
    tests_run++;
    if (got_q.size() != base + 1) begin tests_failed++; $display("FAIL reset_restart_count: got %0d expected 1", got_q.size() - base); end
    else begin
      tests_run++;
      if (got_q[base] !== 16'h1234) begin tests_failed++; $display("FAIL reset_restart_word: got %h expected 1234", got_q[base]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_epb();
    test_start_code();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
